// File: rtl/cnn1d_frame_ctrl.sv
// cnn1d_frame_ctrl
// Inference sequencer between the ADC sample stream and the 1-D CNN datapath.
// Each inference passes exactly FRAME_LEN accepted samples through to the
// CNN. The block then waits for the CNN condition result, or gives up after
// TIMEOUT cycles, and holds the outcome on a ready/valid result port. After
// the result is taken it either re-arms straight away (continuous) or idles.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   start, continuous, abort  host control (start/abort are 1-cycle pulses)
//   busy                      high whenever not idle
//   ctrl_valid_in/ready_in/data_in    ADC sample stream in
//   ctrl_valid_out/ready_out/data_out sample stream toward the CNN
//   res_valid_in/ready_in/condition_in CNN result handshake
//   result_valid/ready/condition/timeout  latched inference outcome
//   frame_count               completed result handshakes (wraps)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, all handshakes closed
// S_STREAM | ADC -> CNN pass-through, counting transfers to FRAME_LEN
// S_DRAIN  | frame sent, waiting for CNN result with timeout timer
// S_RESULT | outcome presented on result_valid until handshake

module cnn1d_frame_ctrl #(
    parameter int ADC_WIDTH       = 12,
    parameter int COND_WIDTH      = 2,
    parameter int FRAME_LEN       = 1024,
    parameter int TIMEOUT         = 65535,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       continuous,
    input  logic                       abort,
    output logic                       busy,
    input  logic                       ctrl_valid_in,
    output logic                       ctrl_ready_in,
    input  logic [ADC_WIDTH-1:0]       ctrl_data_in,
    output logic                       ctrl_valid_out,
    input  logic                       ctrl_ready_out,
    output logic [ADC_WIDTH-1:0]       ctrl_data_out,
    input  logic                       res_valid_in,
    output logic                       res_ready_in,
    input  logic [COND_WIDTH-1:0]      res_condition_in,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [COND_WIDTH-1:0]      result_condition,
    output logic                       result_timeout,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam int SCW = $clog2(FRAME_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [SCW-1:0] FRAME_LAST = SCW'(FRAME_LEN - 1);
    localparam logic [TCW-1:0] TMR_LOAD   = TCW'(TIMEOUT - 1);

    logic [1:0]                 state;
    logic [SCW-1:0]             smp_cnt;
    logic [TCW-1:0]             tmr;
    logic [COND_WIDTH-1:0]      cond_q;
    logic                       timeout_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

    logic in_stream;
    logic xfer;

    assign in_stream = (state == S_STREAM);
    assign xfer      = in_stream & ctrl_valid_in & ctrl_ready_out;

    // Zero-latency pass-through; data is not gated because valid qualifies it.
    assign ctrl_valid_out   = in_stream & ctrl_valid_in;
    assign ctrl_ready_in    = in_stream & ctrl_ready_out;
    assign ctrl_data_out    = ctrl_data_in;

    assign res_ready_in     = (state == S_DRAIN);
    assign result_valid     = (state == S_RESULT);
    assign busy             = (state != S_IDLE);
    assign result_condition = cond_q;
    assign result_timeout   = timeout_q;
    assign frame_count      = frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            smp_cnt     <= '0;
            tmr         <= '0;
            cond_q      <= '0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else if (abort) begin
            // Latched condition and frame count survive an abort on purpose.
            state   <= S_IDLE;
            smp_cnt <= '0;
            tmr     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_STREAM;
                        smp_cnt <= '0;
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        smp_cnt <= smp_cnt + SCW'(1);
                        if (smp_cnt == FRAME_LAST) begin
                            state <= S_DRAIN;
                            tmr   <= TMR_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    // A result on the expiry cycle takes precedence.
                    if (res_valid_in) begin
                        cond_q    <= res_condition_in;
                        timeout_q <= 1'b0;
                        state     <= S_RESULT;
                    end else if (tmr == '0) begin
                        timeout_q <= 1'b1;
                        state     <= S_RESULT;
                    end else begin
                        tmr <= tmr - TCW'(1);
                    end
                end
                S_RESULT: begin
                    if (result_ready) begin
                        frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
                        if (continuous) begin
                            state   <= S_STREAM;
                            smp_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn1d_frame_ctrl.sv
// Self-checking bench for cnn1d_frame_ctrl with FRAME_LEN=4, TIMEOUT=8.
// Expected behaviour is tracked as frame-level bookkeeping: transfers per
// frame, cycles spent waiting for a result, last good condition and the
// number of completed handshakes.
module tb_cnn1d_frame_ctrl;

    localparam int AW  = 12;
    localparam int CW  = 2;
    localparam int FL  = 4;
    localparam int TO  = 8;
    localparam int FCW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, continuous, abort;
    logic           busy;
    logic           ctrl_valid_in, ctrl_ready_in;
    logic [AW-1:0]  ctrl_data_in, ctrl_data_out;
    logic           ctrl_valid_out, ctrl_ready_out;
    logic           res_valid_in, res_ready_in;
    logic [CW-1:0]  res_condition_in, result_condition;
    logic           result_valid, result_ready, result_timeout;
    logic [FCW-1:0] frame_count;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             exp_fc  = 0;
    logic [CW-1:0]  exp_cond = '0;
    logic           exp_to   = 1'b0;

    cnn1d_frame_ctrl #(
        .ADC_WIDTH(AW), .COND_WIDTH(CW), .FRAME_LEN(FL),
        .TIMEOUT(TO), .FRAME_CNT_WIDTH(FCW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .abort(abort), .busy(busy),
        .ctrl_valid_in(ctrl_valid_in), .ctrl_ready_in(ctrl_ready_in),
        .ctrl_data_in(ctrl_data_in), .ctrl_valid_out(ctrl_valid_out),
        .ctrl_ready_out(ctrl_ready_out), .ctrl_data_out(ctrl_data_out),
        .res_valid_in(res_valid_in), .res_ready_in(res_ready_in),
        .res_condition_in(res_condition_in), .result_valid(result_valid),
        .result_ready(result_ready), .result_condition(result_condition),
        .result_timeout(result_timeout), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; continuous = 0; abort = 0;
        ctrl_valid_in = 0; ctrl_ready_out = 0; ctrl_data_in = '0;
        res_valid_in = 0; res_condition_in = '0; result_ready = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready_in"}, ctrl_ready_in, 0);
        chk({tag, "_valid_out"}, ctrl_valid_out, 0);
        chk({tag, "_res_ready"}, res_ready_in, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_cond"}, result_condition, 0);
        chk({tag, "_timeout"}, result_timeout, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
    endtask

    task automatic pulse_start();
        start = 1; ctrl_valid_in = 1; ctrl_ready_out = 1;
        #2;
        chk("idle_ready_in", ctrl_ready_in, 0);
        chk("idle_valid_out", ctrl_valid_out, 0);
        chk("idle_busy", busy, 0);
        tick();
        start = 0;
    endtask

    // Push samples until FL transfers have happened; the DUT must pass the
    // handshake through for every one of them and close right after the last.
    task automatic stream_frame(input bit rnd);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        while (n < FL && cyc < 200) begin
            ctrl_valid_in  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ctrl_ready_out = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ctrl_data_in   = AW'($urandom);
            #2;
            chk("stream_busy", busy, 1);
            chk("stream_ready_in", ctrl_ready_in, ctrl_ready_out);
            chk("stream_valid_out", ctrl_valid_out, ctrl_valid_in);
            if (ctrl_valid_in && ctrl_ready_out) begin
                chk("stream_data", ctrl_data_out, ctrl_data_in);
                n++;
            end
            tick();
            cyc++;
        end
        if (n < FL) chk("stream_bound", n, FL);
        ctrl_valid_in = 1; ctrl_ready_out = 1;
        #2;
        chk("post_frame_ready_in", ctrl_ready_in, 0);
        chk("post_frame_valid_out", ctrl_valid_out, 0);
        chk("post_frame_res_ready", res_ready_in, 1);
        ctrl_valid_in = 0; ctrl_ready_out = 0;
    endtask

    // delay < TO: CNN answers on that DRAIN cycle; delay >= TO: never answers.
    task automatic drain(input int delay, input logic [CW-1:0] cond);
        for (int k = 0; k < TO; k++) begin
            res_valid_in     = (k == delay);
            res_condition_in = (k == delay) ? cond : CW'($urandom);
            start            = (k == 1);
            #2;
            chk("drain_res_ready", res_ready_in, 1);
            chk("drain_no_result", result_valid, 0);
            chk("drain_busy", busy, 1);
            tick();
            if (k == delay) break;
        end
        res_valid_in = 0;
        start = 0;
        if (delay < TO) begin
            exp_cond = cond;
            exp_to   = 1'b0;
        end else begin
            exp_to   = 1'b1;
        end
    endtask

    task automatic result_hs(input int hold, input bit cont);
        result_ready = 0;
        continuous   = cont;
        for (int h = 0; h < hold; h++) begin
            res_valid_in     = 1;
            res_condition_in = ~exp_cond;
            #2;
            chk("result_valid_hold", result_valid, 1);
            chk("result_cond_hold", result_condition, exp_cond);
            chk("result_timeout_hold", result_timeout, exp_to);
            chk("result_res_ready", res_ready_in, 0);
            chk("result_fc_hold", frame_count, exp_fc);
            tick();
        end
        res_valid_in = 0;
        result_ready = 1;
        #2;
        chk("result_valid", result_valid, 1);
        chk("result_cond", result_condition, exp_cond);
        chk("result_timeout", result_timeout, exp_to);
        tick();
        result_ready = 0;
        continuous   = 0;
        exp_fc       = (exp_fc + 1) % (1 << FCW);
        chk("hs_frame_count", frame_count, exp_fc);
        chk("hs_busy", busy, cont);
        chk("hs_result_valid", result_valid, 0);
    endtask

    initial begin
        logic [CW-1:0] conds [3];
        logic [CW-1:0] c;
        clear_inputs();
        rst = 0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        tick();

        // basic frame, condition 2'b10
        pulse_start();
        stream_frame(0);
        drain(5, 2'b10);
        result_hs(2, 0);

        // randomised backpressure on both sides of the stream
        for (int f = 0; f < 4; f++) begin
            pulse_start();
            stream_frame(1);
            drain($urandom_range(0, TO - 1), CW'($urandom));
            result_hs($urandom_range(0, 3), 0);
        end

        // timeout keeps the previous condition
        pulse_start();
        stream_frame(1);
        drain(TO, '0);
        result_hs(1, 0);

        // result on the expiry cycle wins
        pulse_start();
        stream_frame(0);
        c = CW'($urandom);
        drain(TO - 1, c);
        result_hs(0, 0);

        // abort after 2 of 4 samples; third transfer still handshakes
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            ctrl_valid_in = 1; ctrl_ready_out = 1; ctrl_data_in = AW'($urandom);
            tick();
        end
        abort = 1;
        #2;
        chk("abort_cycle_ready_in", ctrl_ready_in, 1);
        tick();
        abort = 0;
        #2;
        chk("abort_busy", busy, 0);
        chk("abort_ready_in", ctrl_ready_in, 0);
        chk("abort_result_valid", result_valid, 0);
        tick();
        ctrl_valid_in = 0; ctrl_ready_out = 0;
        pulse_start();
        stream_frame(0);
        drain(3, 2'b01);
        result_hs(1, 0);

        // abort in RESULT, then start+abort together, then timeout shows retained cond
        pulse_start();
        stream_frame(1);
        drain(2, 2'b11);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_res_valid", result_valid, 0);
        chk("abort_res_busy", busy, 0);
        chk("abort_res_fc", frame_count, exp_fc);
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        chk("start_abort_busy", busy, 0);
        pulse_start();
        stream_frame(0);
        drain(TO, '0);
        result_hs(0, 0);

        // asynchronous reset in the middle of DRAIN
        pulse_start();
        stream_frame(0);
        tick();
        #1;
        rst = 0;
        #1;
        check_reset_outputs("async_reset");
        exp_fc = 0; exp_cond = '0; exp_to = 1'b0;
        tick();
        rst = 1;
        tick();

        // continuous mode: three back-to-back frames
        conds[0] = 2'd1; conds[1] = 2'd3; conds[2] = 2'd0;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            stream_frame(1);
            drain($urandom_range(0, TO - 1), conds[f]);
            result_hs(1, f < 2);
        end
        chk("continuous_fc", frame_count, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn1d_frame_ctrl.md
Name: cnn1d_frame_ctrl

Overview:
Inference sequencer between the ADC sample stream and the m08_cnn1d datapath. It gates exactly FRAME_LEN accepted samples into the CNN per inference and waits for the CNN's condition result, or a timeout. It then presents the result on a ready/valid output and either re-arms automatically (continuous mode) or returns to idle. It also provides abort, a busy flag and a frame counter for the host/top level.

Parameters:
ADC_WIDTH, 12, width of ADC sample passed through to the CNN
COND_WIDTH, 2, width of the CNN condition/class result
FRAME_LEN, 1024, number of accepted samples per inference (>=1)
TIMEOUT, 65535, max cycles in DRAIN waiting for a CNN result (>=1)
FRAME_CNT_WIDTH, 16, width of completed-frame counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a frame when IDLE
continuous  in  1  sampled in RESULT at handshake; 1 = re-arm immediately
abort  in  1  single-cycle pulse; return to IDLE from any state
busy  out  1  high in every state except IDLE
ctrl_valid_in  in  1  ADC sample valid
ctrl_ready_in  out  1  ready toward ADC
ctrl_data_in  in  ADC_WIDTH  ADC sample
ctrl_valid_out  out  1  sample valid toward CNN (cnn_valid_in)
ctrl_ready_out  in  1  CNN ready (cnn_ready_in)
ctrl_data_out  out  ADC_WIDTH  sample toward CNN
res_valid_in  in  1  CNN result valid
res_ready_in  out  1  ready toward CNN result (cnn_ready_out)
res_condition_in  in  COND_WIDTH  CNN condition
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_condition  out  COND_WIDTH  latched condition
result_timeout  out  1  1 = frame ended by timeout, condition invalid
frame_count  out  FRAME_CNT_WIDTH  completed frames (result handshakes)

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0, result_condition 0, result_timeout 0, frame_count 0, all valid/ready outputs 0, busy 0.
- States: IDLE, STREAM, DRAIN, RESULT.
- IDLE: ctrl_ready_in=0, ctrl_valid_out=0, res_ready_in=0. start=1 -> STREAM next cycle, sample counter cleared.
- STREAM: combinational pass-through, zero latency: ctrl_valid_out = ctrl_valid_in; ctrl_ready_in = ctrl_ready_out; ctrl_data_out = ctrl_data_in. A transfer is ctrl_valid_in & ctrl_ready_out; each transfer increments the sample counter. On the transfer that makes the count FRAME_LEN -> DRAIN, timeout counter cleared. Outside STREAM, ctrl_valid_out=0 and ctrl_ready_in=0; ctrl_data_out may hold any value.
- DRAIN: res_ready_in=1. res_valid_in=1 -> latch res_condition_in, result_timeout<=0, go to RESULT. Otherwise the timeout counter increments; when it reaches TIMEOUT-1 with no result -> RESULT, result_timeout<=1, result_condition holds its previous value. A result arriving on the same cycle as expiry wins (timeout=0).
- RESULT: result_valid=1, result_condition/result_timeout stable until handshake. On result_valid & result_ready: frame_count++ (wraps modulo 2^FRAME_CNT_WIDTH); continuous=1 -> STREAM with sample counter cleared, else -> IDLE. res_ready_in=0 here; late CNN results are back-pressured.
- abort: highest priority in every state -> IDLE next cycle, counters cleared, result_valid drops, frame_count unchanged, latched condition retained. A STREAM transfer on the abort cycle still completes at the interface and is not counted. abort and start in the same cycle -> IDLE (start ignored).
- start outside IDLE is ignored.
- busy is registered state decode (busy = state != IDLE).
- FRAME_LEN=1: a single transfer moves STREAM -> DRAIN.
- Counter widths: $clog2(FRAME_LEN+1) and $clog2(TIMEOUT+1).

Test Plan:
- Basic frame: FRAME_LEN=4, ADC always valid, CNN always ready, start pulse -> exactly 4 samples pass, ctrl_ready_in drops the cycle after the 4th; res_valid_in with condition 2'b10 after 10 cycles -> result_valid=1, result_condition=2'b10, timeout=0; result_ready -> frame_count=1, busy=0.
- Backpressure: CNN ready toggles randomly and ADC valid toggles randomly -> exactly FRAME_LEN transfers counted, data_out equals data_in on every transfer, no sample dropped or duplicated.
- Timeout: TIMEOUT=8, no res_valid_in -> RESULT entered 8 cycles after DRAIN entry, result_timeout=1, condition equals the previous frame's value.
- Continuous: continuous=1, three frames with conditions 1,3,0 -> three result handshakes in order, no return to IDLE between them, frame_count=3.
- Abort mid-STREAM after 2 of 4 samples -> IDLE next cycle, ctrl_ready_in=0, no result_valid; a subsequent start runs a full 4-sample frame.
- Async reset asserted mid-DRAIN -> all outputs 0 immediately, without waiting for a clock edge; state returns to IDLE.
